alu: RTL and testbench

//  16-bit integer ALU of the CPU execute stage: 8 ops (add, sub, and, or, not, xor, lsr, lsl)
//  on two register operands. Produces a result plus N/Z/C/P condition flags.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_if.sv | 27 ++
 rtl/alu_datapath.sv | 58 +++++
 rtl/alu.sv | 68 ++++++
 tb/tb_alu.sv | 114 +++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the execute-stage ALU.
//   ALU_W      datapath width (16)
//   OP_*       3-bit operation encodings
package alu_pkg;

    localparam int unsigned ALU_W = 16;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_XOR = 3'b101;
    localparam logic [2:0] OP_LSR = 3'b110;
    localparam logic [2:0] OP_LSL = 3'b111;

endpackage

// File: rtl/alu_if.sv
// alu_if: operand/result bundle between an ALU requester and the ALU datapath.
//   rs, rt, op          operands and operation select (requester -> ALU)
//   rd, f_n/f_z/f_c/f_p result and condition flags   (ALU -> requester)
interface alu_if
    import alu_pkg::*;
();

    logic [ALU_W-1:0] rs;
    logic [ALU_W-1:0] rt;
    logic [2:0]       op;
    logic [ALU_W-1:0] rd;
    logic             f_n;
    logic             f_z;
    logic             f_c;
    logic             f_p;

    modport master (
        output rs, rt, op,
        input  rd, f_n, f_z, f_c, f_p
    );

    modport slave (
        input  rs, rt, op,
        output rd, f_n, f_z, f_c, f_p
    );

endinterface

// File: rtl/alu_datapath.sv
// alu_datapath: purely combinational op mux, 17-bit add/sub and flag derivation.
//   bus.rs/rt/op   operands and op select
//   bus.rd         16-bit result
//   bus.f_n/z/c/p  negative, zero, carry/borrow/shift-out, positive
module alu_datapath
    import alu_pkg::*;
(
    alu_if.slave bus
);

    logic [ALU_W:0]   sum;
    logic [ALU_W-1:0] res;
    logic             carry;

    always_comb begin
        sum   = '0;
        res   = '0;
        carry = 1'b0;
        case (bus.op)
            OP_ADD: begin
                sum   = {1'b0, bus.rs} + {1'b0, bus.rt};
                res   = sum[ALU_W-1:0];
                carry = sum[ALU_W];
            end
            OP_SUB: begin
                // Bit 16 of the zero-extended difference is set exactly when rs < rt.
                sum   = {1'b0, bus.rs} - {1'b0, bus.rt};
                res   = sum[ALU_W-1:0];
                carry = sum[ALU_W];
            end
            OP_AND: res = bus.rs & bus.rt;
            OP_ORR: res = bus.rs | bus.rt;
            OP_NOT: res = ~bus.rs;
            OP_XOR: res = bus.rs ^ bus.rt;
            OP_LSR: begin
                res   = {1'b0, bus.rs[ALU_W-1:1]};
                carry = bus.rs[0];
            end
            OP_LSL: begin
                res   = {bus.rs[ALU_W-2:0], 1'b0};
                carry = bus.rs[ALU_W-1];
            end
            default: begin
                res   = '0;
                carry = 1'b0;
            end
        endcase
    end

    always_comb begin
        bus.rd  = res;
        bus.f_n = res[ALU_W-1];
        bus.f_z = (res == '0);
        bus.f_c = carry;
        bus.f_p = ~res[ALU_W-1] & (res != '0);
    end

endmodule

// File: rtl/alu.sv
// alu: 16-bit execute-stage ALU with registered result and N/Z/C/P flags.
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset (clears rd and all flags)
//   rs, rt, op   operands and op select, sampled every rising edge
//   rd           registered result
//   fN/fZ/fC/fP  registered negative/zero/carry/positive flags
module alu
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ALU_W-1:0] rs,
    input  logic [ALU_W-1:0] rt,
    input  logic [2:0]       op,
    output logic             fN,
    output logic             fZ,
    output logic             fC,
    output logic             fP,
    output logic [ALU_W-1:0] rd
);

    alu_if dp_if ();

    assign dp_if.rs = rs;
    assign dp_if.rt = rt;
    assign dp_if.op = op;

    alu_datapath u_datapath (
        .bus (dp_if.slave)
    );

    logic [ALU_W-1:0] rd_d, rd_q;
    logic             fn_d, fn_q;
    logic             fz_d, fz_q;
    logic             fc_d, fc_q;
    logic             fp_d, fp_q;

    always_comb begin
        rd_d = dp_if.rd;
        fn_d = dp_if.f_n;
        fz_d = dp_if.f_z;
        fc_d = dp_if.f_c;
        fp_d = dp_if.f_p;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q <= '0;
            fn_q <= 1'b0;
            fz_q <= 1'b0;
            fc_q <= 1'b0;
            fp_q <= 1'b0;
        end else begin
            rd_q <= rd_d;
            fn_q <= fn_d;
            fz_q <= fz_d;
            fc_q <= fc_d;
            fp_q <= fp_d;
        end
    end

    assign rd = rd_q;
    assign fN = fn_q;
    assign fZ = fz_q;
    assign fC = fc_q;
    assign fP = fp_q;

endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector bench for alu; each vector carries a hand-computed
// result and NZCP flag nibble.
module tb_alu;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rs    (bus.rs),
        .rt    (bus.rt),
        .op    (bus.op),
        .fN    (bus.f_n),
        .fZ    (bus.f_z),
        .fC    (bus.f_c),
        .fP    (bus.f_p),
        .rd    (bus.rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compares {rd, N, Z, C, P} against the expected value.
    task automatic check_out(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got rd=%h nzcp=%b, expected rd=%h nzcp=%b",
                     tag, got[19:4], got[3:0], exp[19:4], exp[3:0]);
        end
    endtask

    function automatic logic [19:0] observed();
        return {bus.rd, bus.f_n, bus.f_z, bus.f_c, bus.f_p};
    endfunction

    // Drive at the falling edge, sample 1 time unit after the next rising edge.
    // Consecutive calls therefore present a new op every cycle.
    task automatic run_vec(input string tag, input logic [2:0] o, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] exp_rd, input logic [3:0] exp_nzcp);
        @(negedge clk);
        bus.op = o;
        bus.rs = a;
        bus.rt = b;
        @(posedge clk);
        #1;
        check_out(tag, observed(), {exp_rd, exp_nzcp});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.op = OP_ADD;
        bus.rs = 16'h1234;
        bus.rt = 16'h1111;

        #1;
        check_out("reset_initial", observed(), 20'h0);
        #11;
        check_out("reset_held_over_edge", observed(), 20'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors: op, rs, rt, rd, NZCP
        run_vec("add_1_2",       OP_ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0001);
        run_vec("add_ffff_1",    OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0110);
        run_vec("add_8000_8000", OP_ADD, 16'h8000, 16'h8000, 16'h0000, 4'b0110);
        run_vec("sub_1_1",       OP_SUB, 16'h0001, 16'h0001, 16'h0000, 4'b0100);
        run_vec("sub_0_1",       OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010);
        run_vec("sub_5_3",       OP_SUB, 16'h0005, 16'h0003, 16'h0002, 4'b0001);
        run_vec("and_6_5",       OP_AND, 16'h0006, 16'h0005, 16'h0004, 4'b0001);
        run_vec("orr_6_5",       OP_ORR, 16'h0006, 16'h0005, 16'h0007, 4'b0001);
        run_vec("xor_6_5",       OP_XOR, 16'h0006, 16'h0005, 16'h0003, 4'b0001);
        run_vec("not_000f",      OP_NOT, 16'h000F, 16'hAAAA, 16'hFFF0, 4'b1000);
        run_vec("lsr_2",         OP_LSR, 16'h0002, 16'hFFFF, 16'h0001, 4'b0001);
        run_vec("lsr_1",         OP_LSR, 16'h0001, 16'hFFFF, 16'h0000, 4'b0110);
        run_vec("lsl_2",         OP_LSL, 16'h0002, 16'hFFFF, 16'h0004, 4'b0001);
        run_vec("lsl_8000",      OP_LSL, 16'h8000, 16'h0000, 16'h0000, 4'b0110);

        // Back-to-back sweep over all 8 ops with rs=8421, rt=1234
        run_vec("b2b_add", OP_ADD, 16'h8421, 16'h1234, 16'h9655, 4'b1000);
        run_vec("b2b_sub", OP_SUB, 16'h8421, 16'h1234, 16'h71ED, 4'b0001);
        run_vec("b2b_and", OP_AND, 16'h8421, 16'h1234, 16'h0020, 4'b0001);
        run_vec("b2b_orr", OP_ORR, 16'h8421, 16'h1234, 16'h9635, 4'b1000);
        run_vec("b2b_not", OP_NOT, 16'h8421, 16'h1234, 16'h7BDE, 4'b0001);
        run_vec("b2b_xor", OP_XOR, 16'h8421, 16'h1234, 16'h9615, 4'b1000);
        run_vec("b2b_lsr", OP_LSR, 16'h8421, 16'h1234, 16'h4210, 4'b0011);
        run_vec("b2b_lsl", OP_LSL, 16'h8421, 16'h1234, 16'h0842, 4'b0011);

        // Asynchronous reset asserted between clock edges while a result is held.
        run_vec("pre_reset_sub", OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 4'b1010);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("reset_async_midop", observed(), 20'h0);
        @(posedge clk);
        #1;
        check_out("reset_held_midop", observed(), 20'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_reset_add", OP_ADD, 16'h0001, 16'h0002, 16'h0003, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
